shift_sub_seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 26 ++
 rtl/shift_sub_seq_divider_cond_subtractor.sv | 37 +++
 rtl/shift_sub_seq_divider.sv | 141 ++++++++++++++
 tb/tb_shift_sub_seq_divider.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Two's-complement helpers work on a MAX_BITS container; callers truncate to their own width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int MAX_BITS = 64;

    function automatic int count_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic logic [MAX_BITS-1:0] twos_neg(input logic [MAX_BITS-1:0] v);
        return ~v + MAX_BITS'(1);
    endfunction

    function automatic logic [MAX_BITS-1:0] twos_mag(input logic [MAX_BITS-1:0] v,
                                                     input logic             neg);
        return neg ? twos_neg(v) : v;
    endfunction

endpackage

// File: rtl/shift_sub_seq_divider_cond_subtractor.sv
// Ripple subtractor a - b built from full-adder cells (b inverted, carry-in 1).
// Combinational; nonneg is the final carry-out, i.e. a >= b unsigned.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module cond_subtractor #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         nonneg
);
    logic [W:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (~b[i]),
            .ci (carry[i]),
            .s  (diff[i]),
            .co (carry[i+1])
        );
    end

    assign nonneg = carry[W];
endmodule

// File: rtl/shift_sub_seq_divider.sv
// Radix-2 restoring divider, signed/unsigned per operation; num_bits+1 cycles start-to-done
// (1 cycle on divide by zero). start is accepted only while idle; busy and done never overlap.
module shift_sub_seq_divider
    import div_pkg::*;
#(
    parameter int num_bits = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sign_op,
    input  logic [num_bits-1:0] dividend,
    input  logic [num_bits-1:0] divisor,
    output logic [num_bits-1:0] quotient,
    output logic [num_bits-1:0] remainder,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero
);
    localparam int N  = num_bits;
    localparam int CW = count_width(num_bits);

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v, input logic neg);
        return N'(twos_mag(MAX_BITS'(v), neg));
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    pr_q, pr_d;
    logic [N-1:0]  dq_q, dq_d;     // dividend magnitude shifting out, quotient shifting in
    logic [N-1:0]  dvs_q, dvs_d;
    logic          q_neg_q, q_neg_d;
    logic          r_neg_q, r_neg_d;
    logic          zero_q, zero_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic          nonneg;

    assign shifted = (pr_q << 1) | {{N{1'b0}}, dq_q[N-1]};

    cond_subtractor #(.W(N + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, dvs_q}),
        .diff   (diff),
        .nonneg (nonneg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dq_d    = neg_n(dividend, sign_op & dividend[N-1]);
                    dvs_d   = neg_n(divisor, sign_op & divisor[N-1]);
                    q_neg_d = sign_op & (dividend[N-1] ^ divisor[N-1]);
                    r_neg_d = sign_op & dividend[N-1];
                    zero_d  = (divisor == '0);
                    pr_d    = '0;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    state_d = (divisor == '0) ? FIX : ITER;
                end
            end
            ITER: begin
                pr_d  = nonneg ? diff : shifted;
                dq_d  = {dq_q[N-2:0], nonneg};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (zero_q) begin
                    // re-negating the captured magnitude recovers the raw dividend
                    quo_d = '1;
                    rem_d = neg_n(dq_q, r_neg_q);
                    dbz_d = 1'b1;
                end else begin
                    quo_d = neg_n(dq_q, q_neg_q);
                    rem_d = neg_n(pr_q[N-1:0], r_neg_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_seq_divider.sv
// Self-checking bench: directed vector table, corner sequences, random ops against an arithmetic model.
module tb_shift_sub_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sign_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_sub_seq_divider #(.num_bits(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sign_op     (sign_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Truncating division computed with wide signed integers; divide by zero per the interface rules.
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output int lat);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
        end else begin
            dz = 1'b0; lat = 33;
            if (s) begin
                q = 32'(sa / sb);
                r = 32'(sa % sb);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Launches one op; inj >= 0 drives a competing start that many cycles after E0.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int inj,
                          output logic [31:0] q, output logic [31:0] r, output logic dz,
                          output int lat);
        @(negedge clk);
        sign_op = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        check("busy_after_E0", 32'(busy), 32'd1);
        check("dbz_cleared_at_start", 32'(div_by_zero), 32'd0);
        while (!done && lat < 60) begin
            if (lat == inj) begin
                start = 1'b1; sign_op = ~s; dividend = 32'd77; divisor = 32'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
        check("busy_low_with_done", 32'(busy), 32'd0);
        q = quotient; r = remainder; dz = div_by_zero;
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("quotient_holds", quotient, q);
    endtask

    task automatic do_vec(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int inj);
        logic [31:0] q, r, eq, er;
        logic        dz, edz;
        int          lat, elat;
        ref_div(s, a, b, eq, er, edz, elat);
        run_op(s, a, b, inj, q, r, dz, lat);
        check({tag, "_quotient"}, q, eq);
        check({tag, "_remainder"}, r, er);
        check({tag, "_div_by_zero"}, 32'(dz), 32'(edz));
        check({tag, "_latency"}, 32'(lat), 32'(elat));
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,         1'b0};
        vecs[1] = '{1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};
        vecs[2] = '{1'b1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2,  32'd2,         1'b0};
        vecs[3] = '{1'b0, 32'h00001234,   32'd0,        32'hFFFFFFFF,  32'h00001234,  1'b1};
        vecs[4] = '{1'b0, 32'd64,         32'd5,        32'd12,        32'd4,         1'b0};
        vecs[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,         1'b0};
        vecs[6] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,         32'h80000000,  1'b0};
        vecs[7] = '{1'b1, 32'hFFFFFF9C,   32'd0,        32'hFFFFFFFF,  32'hFFFFFF9C,  1'b1};
        vecs[8] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE,  1'b0};
        vecs[9] = '{1'b0, 32'd5,          32'd9,        32'd0,         32'd5,         1'b0};

        #12;
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            logic [31:0] q, r;
            logic        dz;
            int          lat;
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, -1, q, r, dz, lat);
            check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d_div_by_zero", i), 32'(dz), 32'(vecs[i].dz));
            check($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].dz ? 32'd1 : 32'd33);
        end

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i % 8 == 5) b = 32'd0;
            do_vec($sformatf("rand%0d", i), 1'(i & 1), a, b, -1);
        end

        do_vec("ignored_start", 1'b0, 32'hFFFFFFFF, 32'd1, 5);

        // Reset in the middle of an operation
        @(negedge clk);
        sign_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) check("midrst_no_pending", {30'd0, done, busy}, 32'd0);
        end
        do_vec("after_rst", 1'b0, 32'd9, 32'd3, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
